huffman_dec_controller: RTL and testbench



---
 rtl/jpeg_huff_pkg.sv | 107 ++++++++++
 rtl/huff_canon_lookup.sv | 46 ++++
 rtl/huffman_dec_controller.sv | 184 ++++++++++++++++++
 tb/tb_huffman_dec_controller.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_huff_pkg.sv
// jpeg_huff_pkg
//   Shared constants for the baseline JPEG luma Huffman decoder: coefficient
//   geometry, the Annex K luma DC/AC tables (BITS/HUFFVAL), the canonical
//   MINCODE/MAXCODE/VALPTR tables derived from them at elaboration, the EOB/ZRL
//   symbol codes and the controller state encoding.
package jpeg_huff_pkg;

    localparam int COEF_W   = 10;
    localparam int NUM_COEF = 64;
    localparam int BLK_W    = COEF_W * NUM_COEF;

    localparam logic [7:0] EOB = 8'h00;
    localparam logic [7:0] ZRL = 8'hF0;

    localparam logic TBL_DC = 1'b0;
    localparam logic TBL_AC = 1'b1;

    typedef enum logic [2:0] {
        IDLE, DC_SYM, DC_AMP, AC_SYM, AC_AMP, DONE, ERR
    } dec_state_e;

    // BITS[i] = number of codes of length i+1
    typedef logic [7:0] bits_t [16];
    // Derived tables, indexed directly by code length (entry 0 unused)
    typedef logic [16:0][15:0] tbl16_t;

    localparam bits_t DC_BITS = '{8'd0, 8'd1, 8'd5, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1,
                                  8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

    localparam logic [7:0] DC_HUFFVAL [12] = '{
        8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
        8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B};

    localparam bits_t AC_BITS = '{8'd0, 8'd2, 8'd1, 8'd3, 8'd3, 8'd2, 8'd4, 8'd3,
                                  8'd5, 8'd5, 8'd4, 8'd4, 8'd0, 8'd0, 8'd1, 8'd125};

    localparam logic [7:0] AC_HUFFVAL [162] = '{
        8'h01, 8'h02, 8'h03, 8'h00, 8'h04, 8'h11, 8'h05, 8'h12,
        8'h21, 8'h31, 8'h41, 8'h06, 8'h13, 8'h51, 8'h61, 8'h07,
        8'h22, 8'h71, 8'h14, 8'h32, 8'h81, 8'h91, 8'hA1, 8'h08,
        8'h23, 8'h42, 8'hB1, 8'hC1, 8'h15, 8'h52, 8'hD1, 8'hF0,
        8'h24, 8'h33, 8'h62, 8'h72, 8'h82, 8'h09, 8'h0A, 8'h16,
        8'h17, 8'h18, 8'h19, 8'h1A, 8'h25, 8'h26, 8'h27, 8'h28,
        8'h29, 8'h2A, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
        8'h3A, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49,
        8'h4A, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h59,
        8'h5A, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69,
        8'h6A, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77, 8'h78, 8'h79,
        8'h7A, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88, 8'h89,
        8'h8A, 8'h92, 8'h93, 8'h94, 8'h95, 8'h96, 8'h97, 8'h98,
        8'h99, 8'h9A, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7,
        8'hA8, 8'hA9, 8'hAA, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6,
        8'hB7, 8'hB8, 8'hB9, 8'hBA, 8'hC2, 8'hC3, 8'hC4, 8'hC5,
        8'hC6, 8'hC7, 8'hC8, 8'hC9, 8'hCA, 8'hD2, 8'hD3, 8'hD4,
        8'hD5, 8'hD6, 8'hD7, 8'hD8, 8'hD9, 8'hDA, 8'hE1, 8'hE2,
        8'hE3, 8'hE4, 8'hE5, 8'hE6, 8'hE7, 8'hE8, 8'hE9, 8'hEA,
        8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6, 8'hF7, 8'hF8,
        8'hF9, 8'hFA};

    // First canonical code of each length
    function automatic tbl16_t f_mincode(input bits_t bits);
        tbl16_t t;
        int     code;
        t    = '0;
        code = 0;
        for (int l = 1; l <= 16; l++) begin
            t[l] = 16'(code);
            code = (code + int'(bits[l-1])) << 1;
        end
        return t;
    endfunction

    // Last canonical code of each length; meaningless where BITS is zero,
    // so the lookup gates on BITS as well
    function automatic tbl16_t f_maxcode(input bits_t bits);
        tbl16_t t;
        int     code;
        t    = '0;
        code = 0;
        for (int l = 1; l <= 16; l++) begin
            t[l] = 16'(code + int'(bits[l-1]) - 1);
            code = (code + int'(bits[l-1])) << 1;
        end
        return t;
    endfunction

    // HUFFVAL index of the first code of each length
    function automatic tbl16_t f_valptr(input bits_t bits);
        tbl16_t t;
        int     k;
        t = '0;
        k = 0;
        for (int l = 1; l <= 16; l++) begin
            t[l] = 16'(k);
            k    = k + int'(bits[l-1]);
        end
        return t;
    endfunction

    localparam tbl16_t DC_MINCODE = f_mincode(DC_BITS);
    localparam tbl16_t DC_MAXCODE = f_maxcode(DC_BITS);
    localparam tbl16_t DC_VALPTR  = f_valptr(DC_BITS);
    localparam tbl16_t AC_MINCODE = f_mincode(AC_BITS);
    localparam tbl16_t AC_MAXCODE = f_maxcode(AC_BITS);
    localparam tbl16_t AC_VALPTR  = f_valptr(AC_BITS);

endpackage

// File: rtl/huff_canon_lookup.sv
// huff_canon_lookup
//   Combinational canonical-Huffman resolver for the luma DC/AC tables.
//   Ports:
//     i_tbl    table select (TBL_DC / TBL_AC)
//     i_code   accumulated code, right-aligned, i_len bits significant
//     i_len    code length 1..16 (anything else never matches)
//     o_match  i_code is a complete codeword of length i_len
//     o_symbol decoded HUFFVAL entry, zero when no match
module huff_canon_lookup
    import jpeg_huff_pkg::*;
(
    input  logic        i_tbl,
    input  logic [15:0] i_code,
    input  logic [4:0]  i_len,
    output logic        o_match,
    output logic [7:0]  o_symbol
);

    logic [3:0]  w_li;
    logic        w_inrange;
    logic [7:0]  w_cnt;
    logic [15:0] w_min;
    logic [15:0] w_max;
    logic [15:0] w_vp;
    logic [7:0]  w_off;
    logic [7:0]  w_idx;

    assign w_li      = 4'(i_len - 5'd1);
    assign w_inrange = (i_len != 5'd0) && (i_len <= 5'd16);

    always_comb begin
        w_cnt    = i_tbl ? AC_BITS[w_li]     : DC_BITS[w_li];
        w_min    = i_tbl ? AC_MINCODE[i_len] : DC_MINCODE[i_len];
        w_max    = i_tbl ? AC_MAXCODE[i_len] : DC_MAXCODE[i_len];
        w_vp     = i_tbl ? AC_VALPTR[i_len]  : DC_VALPTR[i_len];
        w_off    = 8'(i_code - w_min);
        w_idx    = w_vp[7:0] + w_off;
        // Shorter prefixes were already rejected, so code >= MINCODE holds
        // whenever code <= MAXCODE at this length
        o_match  = w_inrange && (w_cnt != 8'd0) && (i_code <= w_max);
        o_symbol = 8'h00;
        if (o_match)
            o_symbol = i_tbl ? AC_HUFFVAL[w_idx] : DC_HUFFVAL[w_idx[3:0]];
    end

endmodule

// File: rtl/huffman_dec_controller.sv
// huffman_dec_controller
//   Serial (one bit/cycle, MSB-first) baseline JPEG luma entropy decoder for
//   one 8x8 block. Builds a zigzag-ordered block of 64 signed 10-bit
//   coefficients; DC is stored as decoded (no prediction).
//   Ports:
//     clock, reset_n   rising-edge clock, async active-low reset
//     decode_start     pulse, starts a block from IDLE or ERR
//     bit_in/bit_valid stream bit and qualifier
//     bit_ready        decoder accepts a bit (any decode state)
//     zigzag_pix_out   coefficient k at [10k+9:10k], k=0 is DC
//     block_done       one-cycle pulse after the final bit
//     dec_error        sticky until the next decode_start
//     busy             block in progress
module huffman_dec_controller
    import jpeg_huff_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             decode_start,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [BLK_W-1:0] zigzag_pix_out,
    output logic             block_done,
    output logic             dec_error,
    output logic             busy
);

    dec_state_e       r_state, w_state_nxt;
    logic [14:0]      r_code,  w_code_nxt;
    logic [4:0]       r_len,   w_len_nxt;
    logic [6:0]       r_k,     w_k_nxt;
    logic [8:0]       r_amp,   w_amp_nxt;
    logic [3:0]       r_size,  w_size_nxt;
    logic [3:0]       r_cnt,   w_cnt_nxt;
    logic [BLK_W-1:0] r_coef,  w_coef_nxt;

    logic        w_xfer;
    logic        w_tbl;
    logic [15:0] w_acc_code;
    logic [4:0]  w_acc_len;
    logic        w_match;
    logic [7:0]  w_sym;
    logic [9:0]  w_amp_sh;
    logic        w_amp_last;
    logic        w_first;
    logic [9:0]  w_mask;
    logic [9:0]  w_val;
    logic [6:0]  w_k_run;
    logic [6:0]  w_k_zrl;

    assign bit_ready = (r_state == DC_SYM) || (r_state == DC_AMP) ||
                       (r_state == AC_SYM) || (r_state == AC_AMP);
    assign busy           = bit_ready;
    assign block_done     = (r_state == DONE);
    assign dec_error      = (r_state == ERR);
    assign zigzag_pix_out = r_coef;

    assign w_xfer = bit_valid && bit_ready;

    // Lookup sees the code including the bit being accepted, so a symbol
    // resolves on the same edge as its last bit
    assign w_tbl      = (r_state == AC_SYM) ? TBL_AC : TBL_DC;
    assign w_acc_code = {r_code, bit_in};
    assign w_acc_len  = r_len + 5'd1;

    huff_canon_lookup u_lookup (
        .i_tbl    (w_tbl),
        .i_code   (w_acc_code),
        .i_len    (w_acc_len),
        .o_match  (w_match),
        .o_symbol (w_sym)
    );

    // Amplitude: leading 1 -> positive as-is, leading 0 -> bits - (2^s - 1)
    assign w_amp_sh   = {r_amp, bit_in};
    assign w_amp_last = ((r_cnt + 4'd1) == r_size);
    assign w_first    = w_amp_sh[r_size - 4'd1];
    assign w_mask     = 10'((11'd1 << r_size) - 11'd1);
    assign w_val      = w_first ? w_amp_sh : (w_amp_sh - w_mask);

    assign w_k_run = r_k + {3'b000, w_sym[7:4]};
    assign w_k_zrl = r_k + 7'd16;

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_len_nxt   = r_len;
        w_k_nxt     = r_k;
        w_amp_nxt   = r_amp;
        w_size_nxt  = r_size;
        w_cnt_nxt   = r_cnt;
        w_coef_nxt  = r_coef;
        case (r_state)
            IDLE, ERR: begin
                if (decode_start) begin
                    w_state_nxt = DC_SYM;
                    w_coef_nxt  = '0;
                    w_k_nxt     = '0;
                    w_code_nxt  = '0;
                    w_len_nxt   = '0;
                    w_amp_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_size_nxt  = '0;
                end
            end
            DC_SYM, AC_SYM: begin
                if (w_xfer) begin
                    w_code_nxt = w_acc_code[14:0];
                    w_len_nxt  = w_acc_len;
                    if (w_match) begin
                        w_code_nxt = '0;
                        w_len_nxt  = '0;
                        w_amp_nxt  = '0;
                        w_cnt_nxt  = '0;
                        if (r_state == DC_SYM) begin
                            if (w_sym == 8'd0) begin
                                w_k_nxt     = 7'd1;
                                w_state_nxt = AC_SYM;
                            end else if (w_sym <= 8'd10) begin
                                w_size_nxt  = w_sym[3:0];
                                w_state_nxt = DC_AMP;
                            end else begin
                                w_state_nxt = ERR;
                            end
                        end else if (w_sym == EOB) begin
                            w_state_nxt = DONE;
                        end else if (w_sym == ZRL) begin
                            if (w_k_zrl > 7'd63) w_state_nxt = ERR;
                            else                 w_k_nxt     = w_k_zrl;
                        end else if ((w_k_run > 7'd63) || (w_sym[3:0] > 4'd10)) begin
                            w_state_nxt = ERR;
                        end else begin
                            w_k_nxt     = w_k_run;
                            w_size_nxt  = w_sym[3:0];
                            w_state_nxt = AC_AMP;
                        end
                    end else if (w_acc_len == 5'd16) begin
                        w_state_nxt = ERR;
                    end
                end
            end
            DC_AMP, AC_AMP: begin
                if (w_xfer) begin
                    w_amp_nxt = w_amp_sh[8:0];
                    w_cnt_nxt = r_cnt + 4'd1;
                    if (w_amp_last) begin
                        w_coef_nxt[COEF_W*int'(r_k) +: COEF_W] = w_val;
                        w_amp_nxt = '0;
                        w_cnt_nxt = '0;
                        w_k_nxt   = r_k + 7'd1;
                        if (r_state == AC_AMP && r_k == 7'd63) w_state_nxt = DONE;
                        else                                   w_state_nxt = AC_SYM;
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_code  <= '0;
            r_len   <= '0;
            r_k     <= '0;
            r_amp   <= '0;
            r_size  <= '0;
            r_cnt   <= '0;
            r_coef  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
            r_len   <= w_len_nxt;
            r_k     <= w_k_nxt;
            r_amp   <= w_amp_nxt;
            r_size  <= w_size_nxt;
            r_cnt   <= w_cnt_nxt;
            r_coef  <= w_coef_nxt;
        end
    end

endmodule

// File: tb/tb_huffman_dec_controller.sv
module tb_huffman_dec_controller;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         decode_start;
    logic         bit_in;
    logic         bit_valid;
    logic         bit_ready;
    logic [639:0] zigzag_pix_out;
    logic         block_done;
    logic         dec_error;
    logic         busy;

    int total = 0;
    int bad   = 0;

    localparam string S_ZRL = "11111111001";

    huffman_dec_controller dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .decode_start   (decode_start),
        .bit_in         (bit_in),
        .bit_valid      (bit_valid),
        .bit_ready      (bit_ready),
        .zigzag_pix_out (zigzag_pix_out),
        .block_done     (block_done),
        .dec_error      (dec_error),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic start_block();
        decode_start = 1'b1;
        @(posedge clock); #1;
        decode_start = 1'b0;
    endtask

    // One bit per cycle; spaces ignored; optional random bit_valid gaps
    // carrying junk on bit_in
    task automatic send_str(input string s, input int max_gap);
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == " ") continue;
            if (max_gap > 0) begin
                int g;
                g = $urandom_range(max_gap, 0);
                repeat (g) begin
                    bit_valid = 1'b0;
                    bit_in    = 1'($urandom);
                    @(posedge clock); #1;
                end
            end
            bit_in    = (s[i] == "1");
            bit_valid = 1'b1;
            @(posedge clock); #1;
            bit_valid = 1'b0;
            bit_in    = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; decode_start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        #12;
        total++; if (bit_ready !== 1'b0) begin bad++; $display("FAIL reset_bit_ready got=%b want=0", bit_ready); end
        total++; if (block_done !== 1'b0) begin bad++; $display("FAIL reset_block_done got=%b want=0", block_done); end
        total++; if (dec_error !== 1'b0) begin bad++; $display("FAIL reset_dec_error got=%b want=0", dec_error); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (zigzag_pix_out !== 640'd0) begin bad++; $display("FAIL reset_coef got=%h want=0", zigzag_pix_out); end
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_empty();
        start_block();
        total++; if ({busy, bit_ready} !== 2'b11) begin bad++; $display("FAIL empty_busy_ready got=%b want=11", {busy, bit_ready}); end
        send_str("00 1010", 0);
        total++; if (block_done !== 1'b1) begin bad++; $display("FAIL empty_done got=%b want=1", block_done); end
        total++; if (zigzag_pix_out !== 640'd0) begin bad++; $display("FAIL empty_coef got=%h want=0", zigzag_pix_out); end
        @(posedge clock); #1;
        total++; if ({block_done, bit_ready, busy} !== 3'b000) begin bad++; $display("FAIL empty_after got=%b want=000", {block_done, bit_ready, busy}); end
    endtask

    task automatic test_dc(input string name, input string s, input logic [9:0] dc);
        logic [639:0] exp;
        exp = '0;
        exp[9:0] = dc;
        start_block();
        send_str(s, 0);
        total++; if (block_done !== 1'b1) begin bad++; $display("FAIL %s_done got=%b want=1", name, block_done); end
        total++; if (zigzag_pix_out !== exp) begin bad++; $display("FAIL %s_coef got=%h want=%h", name, zigzag_pix_out, exp); end
        @(posedge clock); #1;
    endtask

    task automatic test_ac_zrl(input string name, input int max_gap);
        logic [639:0] exp;
        exp = '0;
        exp[10 +: 10]  = 10'h001;
        exp[180 +: 10] = 10'h3FF;
        start_block();
        send_str({"00 00 1 ", S_ZRL, " 00 0 1010"}, max_gap);
        total++; if (block_done !== 1'b1) begin bad++; $display("FAIL %s_done got=%b want=1", name, block_done); end
        total++; if (zigzag_pix_out !== exp) begin bad++; $display("FAIL %s_coef got=%h want=%h", name, zigzag_pix_out, exp); end
        @(posedge clock); #1;
    endtask

    task automatic test_full();
        logic [639:0] exp;
        string s;
        exp = '0;
        for (int i = 1; i < 64; i++) exp[10*i +: 10] = 10'h001;
        s = "00";
        for (int i = 0; i < 63; i++) s = {s, "001"};
        start_block();
        send_str(s.substr(0, s.len() - 2), 0);
        total++; if ({block_done, busy} !== 2'b01) begin bad++; $display("FAIL full_early got=%b want=01", {block_done, busy}); end
        send_str("1", 0);
        total++; if (block_done !== 1'b1) begin bad++; $display("FAIL full_done got=%b want=1", block_done); end
        total++; if (zigzag_pix_out !== exp) begin bad++; $display("FAIL full_coef got=%h want=%h", zigzag_pix_out, exp); end
        @(posedge clock); #1;
    endtask

    task automatic test_bad_code();
        logic [639:0] exp;
        exp = '0;
        exp[9:0] = 10'd5;
        start_block();
        send_str("111111111111111", 0);
        total++; if ({dec_error, bit_ready} !== 2'b01) begin bad++; $display("FAIL badcode_15 got=%b want=01", {dec_error, bit_ready}); end
        send_str("1", 0);
        total++; if ({dec_error, bit_ready, busy} !== 3'b100) begin bad++; $display("FAIL badcode_err got=%b want=100", {dec_error, bit_ready, busy}); end
        bit_in = 1'b1; bit_valid = 1'b1;
        repeat (3) begin @(posedge clock); #1; end
        bit_valid = 1'b0;
        total++; if (dec_error !== 1'b1) begin bad++; $display("FAIL badcode_sticky got=%b want=1", dec_error); end
        start_block();
        total++; if ({dec_error, bit_ready} !== 2'b01) begin bad++; $display("FAIL badcode_clear got=%b want=01", {dec_error, bit_ready}); end
        send_str("100 101 1010", 0);
        total++; if (zigzag_pix_out !== exp || block_done !== 1'b1) begin bad++; $display("FAIL badcode_recover got=%h/%b want=%h/1", zigzag_pix_out, block_done, exp); end
        @(posedge clock); #1;
    endtask

    task automatic test_dc_cat11();
        start_block();
        send_str("111111110", 0);
        total++; if (dec_error !== 1'b1) begin bad++; $display("FAIL dc_cat11_err got=%b want=1", dec_error); end
    endtask

    task automatic test_zrl_overflow();
        start_block();
        send_str({"00 ", S_ZRL, S_ZRL, S_ZRL}, 0);
        total++; if ({dec_error, bit_ready} !== 2'b01) begin bad++; $display("FAIL zrl_k49 got=%b want=01", {dec_error, bit_ready}); end
        send_str(S_ZRL, 0);
        total++; if (dec_error !== 1'b1) begin bad++; $display("FAIL zrl_overflow got=%b want=1", dec_error); end
    endtask

    task automatic test_start_ignored();
        logic [639:0] exp;
        exp = '0;
        exp[9:0] = 10'd5;
        start_block();
        send_str("100", 0);
        start_block();
        send_str("101 1010", 0);
        total++; if (zigzag_pix_out !== exp || block_done !== 1'b1) begin bad++; $display("FAIL start_busy got=%h/%b want=%h/1", zigzag_pix_out, block_done, exp); end
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid();
        logic [639:0] exp;
        exp = '0;
        exp[9:0] = 10'h3FB;
        start_block();
        send_str("100 101 00", 0);
        total++; if ({bit_ready, zigzag_pix_out[9:0]} !== {1'b1, 10'd5}) begin bad++; $display("FAIL rstmid_pre got=%b/%h want=1/005", bit_ready, zigzag_pix_out[9:0]); end
        #2 reset_n = 1'b0;
        #1;
        total++; if ({bit_ready, block_done, dec_error, busy} !== 4'b0000) begin bad++; $display("FAIL rstmid_flags got=%b want=0000", {bit_ready, block_done, dec_error, busy}); end
        total++; if (zigzag_pix_out !== 640'd0) begin bad++; $display("FAIL rstmid_coef got=%h want=0", zigzag_pix_out); end
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        start_block();
        send_str("100 010 1010", 0);
        total++; if (zigzag_pix_out !== exp || block_done !== 1'b1) begin bad++; $display("FAIL rstmid_after got=%h/%b want=%h/1", zigzag_pix_out, block_done, exp); end
        @(posedge clock); #1;
    endtask

    initial begin
        test_reset();
        test_empty();
        test_dc("dc_pos5", "100 101 1010", 10'd5);
        test_dc("dc_neg5", "100 010 1010", 10'h3FB);
        test_ac_zrl("ac_zrl", 0);
        test_full();
        test_bad_code();
        test_dc_cat11();
        test_zrl_overflow();
        test_start_ignored();
        test_ac_zrl("stall_ac_zrl", 3);
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
